// File: rtl/fmap_feeder_pkg.sv
// Shared CNN constants and feeder FSM encoding.
// Used by fmap_feeder and fmap_ram.
package fmap_feeder_pkg;

  localparam int FMAP_I_BW    = 16;
  localparam int FMAP_IF_SIZE = 28;
  localparam int FMAP_ADDR_BW = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DONE
  } feed_state_t;

endpackage

// File: rtl/fmap_ram.sv
// Feature-map buffer bank: one write port, one synchronous read port.
// Read data holds its value whenever no read is issued.
module fmap_ram
  import fmap_feeder_pkg::*;
#(
  parameter int DW = FMAP_I_BW,
  parameter int AW = FMAP_ADDR_BW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; storage survives reset.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fmap_feeder.sv
// Buffers one feature map and streams it in raster order to a conv layer.
// Define FMAP_FEEDER_PINGPONG_EN for two banks (load while streaming).
module fmap_feeder
  import fmap_feeder_pkg::*;
#(
  parameter int I_BW    = FMAP_I_BW,
  parameter int IF_SIZE = FMAP_IF_SIZE,
  parameter int ADDR_BW = FMAP_ADDR_BW
) (
  input  logic                   clk,
  input  logic                   global_rst_n,
  input  logic                   i_wr_en,
  input  logic [ADDR_BW-1:0]     i_wr_addr,
  input  logic signed [I_BW-1:0] i_wr_data,
  input  logic                   i_start,
  input  logic                   i_hold,
  output logic signed [I_BW-1:0] o_fmap,
  output logic                   o_ce,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int NPIX = IF_SIZE * IF_SIZE;
  localparam logic [ADDR_BW:0] NPIX_A = (ADDR_BW+1)'(NPIX);

  feed_state_t      state, state_nx;
  logic [ADDR_BW:0] addr, addr_nx;
  logic             ce_nx;
  logic             rd_en;
  logic             start_ok;
  logic             in_range;
  logic             wr_ok;
  logic [I_BW-1:0]  rdata0;

  assign in_range = {1'b0, i_wr_addr} < NPIX_A;
  assign o_busy   = (state == S_PRIME) || (state == S_STREAM);
  assign o_done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!global_rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
      o_ce  <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      o_ce  <= ce_nx;
    end
  end

  // addr counts issued reads; reaching NPIX means the last read is out.
  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    ce_nx    = 1'b0;
    rd_en    = 1'b0;
    start_ok = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          start_ok = 1'b1;
          addr_nx  = '0;
          state_nx = S_PRIME;
        end
      end
      S_PRIME: begin
        rd_en    = 1'b1;
        ce_nx    = 1'b1;
        addr_nx  = addr + 1'b1;
        state_nx = S_STREAM;
      end
      S_STREAM: begin
        if (addr == NPIX_A) begin
          state_nx = S_DONE;
        end else if (!i_hold) begin
          rd_en   = 1'b1;
          ce_nx   = 1'b1;
          addr_nx = addr + 1'b1;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef FMAP_FEEDER_PINGPONG_EN
  logic            wr_bank;
  logic            rd_bank;
  logic            loaded;
  logic [I_BW-1:0] rdata1;

  assign wr_ok = i_wr_en && in_range;

  // Banks swap only on a start that follows fresh loads.
  always_ff @(posedge clk) begin
    if (!global_rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b1;
      loaded  <= 1'b0;
    end else if (start_ok && loaded) begin
      rd_bank <= wr_bank;
      wr_bank <= ~wr_bank;
      loaded  <= 1'b0;
    end else if (wr_ok) begin
      loaded  <= 1'b1;
    end
  end

  fmap_ram #(.DW(I_BW), .AW(ADDR_BW)) u_bank0 (
    .clk     (clk),
    .rst_n   (global_rst_n),
    .wr_en   (wr_ok && !wr_bank),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_en   (rd_en && !rd_bank),
    .rd_addr (addr[ADDR_BW-1:0]),
    .rd_data (rdata0)
  );

  fmap_ram #(.DW(I_BW), .AW(ADDR_BW)) u_bank1 (
    .clk     (clk),
    .rst_n   (global_rst_n),
    .wr_en   (wr_ok && wr_bank),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_en   (rd_en && rd_bank),
    .rd_addr (addr[ADDR_BW-1:0]),
    .rd_data (rdata1)
  );

  assign o_fmap = rd_bank ? rdata1 : rdata0;
`else
  assign wr_ok = i_wr_en && in_range && !o_busy;

  fmap_ram #(.DW(I_BW), .AW(ADDR_BW)) u_bank0 (
    .clk     (clk),
    .rst_n   (global_rst_n),
    .wr_en   (wr_ok),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr[ADDR_BW-1:0]),
    .rd_data (rdata0)
  );

  assign o_fmap = rdata0;
`endif

endmodule
